// File: rtl/lcd_frame_writer.sv
// ---------------------------------------------------------------------------
// lcd_frame_writer
//
// Holds a 2x16 character frame buffer and streams it to a character-LCD
// driver as 34 words: a line-1 cursor command, 16 characters, a line-2
// cursor command and 16 more characters.  Each word is handed over with a
// one-cycle data_ready strobe and a busy/not-busy handshake on lcd_busy.
// If the driver never raises lcd_busy after a strobe, the same word is
// re-issued after ACK_TIMEOUT cycles.
//
// A refresh pulse during a transfer queues exactly one further frame.
//
// Optional build macro:
//   LCD_FRAME_WRITER_AUTO_REFRESH_EN - every buffer write also requests a
//   frame, so edits reach the display without an explicit refresh pulse.
//   Undefined (default): only refresh starts or queues a frame.
// ---------------------------------------------------------------------------
module lcd_frame_writer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic       lcd_busy,
    output logic [8:0] d_out,
    output logic       data_ready,
    output logic       active,
    output logic       done
);

    // FSM encoding
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_FREE = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    // Word positions inside a frame
    localparam logic [5:0] LINE1_CMD_IDX = 6'd0;
    localparam logic [5:0] LINE2_CMD_IDX = 6'd17;
    localparam logic [5:0] LAST_IDX      = 6'd33;

    // LCD commands that place the cursor at the start of each line
    localparam logic [7:0] LINE1_CMD = 8'h80;
    localparam logic [7:0] LINE2_CMD = 8'hC0;
    localparam logic [7:0] SPACE     = 8'h20;

    // Acknowledge-timeout counter sized to hold ACK_TIMEOUT
    localparam int            TW          = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(ACK_TIMEOUT);

    // Registered state
    logic [1:0]    r_state;
    logic [5:0]    r_idx;
    logic          r_pending;
    logic [TW-1:0] r_timeout;
    logic [8:0]    r_d_out;
    logic          r_data_ready;
    logic          r_active;
    logic          r_done;
    logic [7:0]    r_buf [32];

    // Combinational helpers
    logic          w_req;
    logic [4:0]    w_cell;
    logic [8:0]    w_word;

    assign d_out      = r_d_out;
    assign data_ready = r_data_ready;
    assign active     = r_active;
    assign done       = r_done;

    // Frame request source: refresh always, buffer writes only when enabled
`ifdef LCD_FRAME_WRITER_AUTO_REFRESH_EN
    assign w_req = refresh | wr_en;
`else
    assign w_req = refresh;
`endif

    // Frame buffer: written on any cycle, cleared to spaces by reset
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: a reset on an array builds it from flops rather than RAM;
        // that is intended here because the power-up frame must be all spaces.
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_buf[i] <= SPACE;
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Map the word index onto the buffer cell it carries (1-16 -> 0-15, 18-33 -> 16-31)
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the block can leave it unassigned and infer a latch.
        w_cell = 5'd0;
        if (r_idx >= 6'd18) begin
            w_cell = 5'(r_idx - 6'd2);
        end else if (r_idx >= 6'd1) begin
            w_cell = 5'(r_idx - 6'd1);
        end
    end

    // Build the word for the current index; characters come straight from the buffer
    always_comb begin
        w_word = {1'b1, r_buf[w_cell]};
        if (r_idx == LINE1_CMD_IDX) begin
            w_word = {1'b0, LINE1_CMD};
        end else if (r_idx == LINE2_CMD_IDX) begin
            w_word = {1'b0, LINE2_CMD};
        end
    end

    // Transfer sequencer: issue, wait for busy to rise, wait for busy to fall
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            r_state      <= IDLE;
            r_idx        <= 6'd0;
            r_pending    <= 1'b0;
            r_timeout    <= '0;
            r_d_out      <= 9'h000;
            r_data_ready <= 1'b0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless reasserted below
            r_data_ready <= 1'b0;
            r_done       <= 1'b0;

            // Requests arriving mid-transfer collapse into a single queued frame
            if (r_state != IDLE && w_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_req || r_pending) begin
                        r_idx     <= 6'd0;
                        r_pending <= 1'b0;
                        r_active  <= 1'b1;
                        r_state   <= WAIT_FREE;
                    end
                end

                WAIT_FREE: begin
                    // Characters are captured here, so late edits to unsent cells still go out
                    if (!lcd_busy) begin
                        r_d_out      <= w_word;
                        r_data_ready <= 1'b1;
                        r_timeout    <= '0;
                        r_state      <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (lcd_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_timeout == TIMEOUT_MAX) begin
                        // Driver missed the strobe: go back and send the same word again
                        r_state <= WAIT_FREE;
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                    end
                end

                WAIT_DONE: begin
                    if (!lcd_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= WAIT_FREE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
